// File: rtl/node_pkg.sv
// Shared definitions for valid/ready node blocks.
package node_pkg;

    localparam int unsigned NODE_WIDTH = 32;

    // Error codes reserved for richer protocol reporting.
    typedef enum logic [1:0] {
        VR_ERR_NONE     = 2'd0,
        VR_ERR_RETRACT  = 2'd1,
        VR_ERR_DATA_CHG = 2'd2
    } vr_err_t;

    // Pointer width for an n-entry array, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vr_protocol_mon.sv
// Watches a valid/ready link and flags a sender that retracts valid or
// changes data while stalled. The flag is sticky until reset.
module vr_protocol_mon
    import node_pkg::*;
#(
    parameter int unsigned WIDTH = NODE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             ready,
    input  logic [WIDTH-1:0] data,
    output logic             err
);

    logic             stall_q;
    logic [WIDTH-1:0] data_q;
    logic             err_q;
    logic             violation_c;

    // A stall last cycle obliges the sender to hold valid and data now.
    always_comb begin
        violation_c = stall_q && (!valid || (data != data_q));
    end

    // History of the previous cycle plus the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= valid && !ready;
            data_q  <= data;
            if (violation_c) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;

endmodule

// File: rtl/node_fifo_validready.sv
// First-word-fall-through elastic buffer between two valid/ready nodes,
// with an upstream handshake monitor.
module node_fifo_validready
    import node_pkg::*;
#(
    parameter  int unsigned WIDTH = NODE_WIDTH,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_up_in,
    output logic             ready_up_out,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    input  logic             ready_down_in,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             proto_err
);

    localparam int unsigned PW = clog2_min1(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             ready_q,  ready_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             up_fire_c;
    logic             down_fire_c;

    // Handshakes use only registered flags, so no input-to-output paths.
    assign up_fire_c   = valid_up_in && ready_q;
    assign down_fire_c = !empty_q && ready_down_in;

    // Next pointers, occupancy and status flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (up_fire_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (down_fire_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({up_fire_c, down_fire_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CW'(DEPTH));
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Storage, pointers and flags; reset discards all contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (up_fire_c) begin
                mem_q[wr_ptr_q] <= data_in;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Upstream handshake monitor; purely observational.
    vr_protocol_mon #(
        .WIDTH (WIDTH)
    ) u_up_mon (
        .clk   (clk),
        .rst   (rst),
        .valid (valid_up_in),
        .ready (ready_q),
        .data  (data_in),
        .err   (proto_err)
    );

    assign ready_up_out   = ready_q;
    assign valid_down_out = !empty_q;
    assign data_out       = mem_q[rd_ptr_q];
    assign count          = count_q;
    assign full           = full_q;
    assign empty          = empty_q;

endmodule

// File: tb/tb_node_fifo_validready.sv
// Randomised and directed checks of node_fifo_validready against a
// queue-based reference model.
module tb_node_fifo_validready;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             valid_up_in;
    logic             ready_up_out;
    logic [WIDTH-1:0] data_out;
    logic             valid_down_out;
    logic             ready_down_in;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             proto_err;

    node_fifo_validready #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .valid_up_in    (valid_up_in),
        .ready_up_out   (ready_up_out),
        .data_out       (data_out),
        .valid_down_out (valid_down_out),
        .ready_down_in  (ready_down_in),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the buffer contents as a queue, plus rule-level state.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ready;
    bit               m_err;
    bit               m_stall;
    logic [WIDTH-1:0] m_prev_d;
    bit               m_up;
    int               accepted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("valid_down", 32'(valid_down_out), 32'(m_q.size() != 0));
        check("ready_up",   32'(ready_up_out),   32'(m_ready));
        check("count",      32'(count),          32'(m_q.size()));
        check("full",       32'(full),           32'(m_q.size() == DEPTH));
        check("empty",      32'(empty),          32'(m_q.size() == 0));
        check("proto_err",  32'(proto_err),      32'(m_err));
        if (m_q.size() != 0) begin
            check("data_out", data_out, m_q[0]);
        end
    endtask

    // One clock with the given inputs; model advances at the edge, outputs
    // are compared at the following falling edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
        bit dn;
        valid_up_in   = v;
        data_in       = d;
        ready_down_in = r;
        m_up = v && m_ready;
        dn   = r && (m_q.size() != 0);
        if (m_stall && (!v || d != m_prev_d)) m_err = 1'b1;
        m_stall  = v && !m_ready;
        m_prev_d = d;
        @(posedge clk);
        if (dn) void'(m_q.pop_front());
        if (m_up) begin
            m_q.push_back(d);
            accepted++;
        end
        m_ready = (m_q.size() != DEPTH);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ready  = 1'b0;
        m_err    = 1'b0;
        m_stall  = 1'b0;
        m_prev_d = '0;
    endtask

    task automatic check_reset_values();
        check("rst_ready_up", 32'(ready_up_out),   32'd0);
        check("rst_valid",    32'(valid_down_out), 32'd0);
        check("rst_data",     data_out,            32'd0);
        check("rst_count",    32'(count),          32'd0);
        check("rst_full",     32'(full),           32'd0);
        check("rst_empty",    32'(empty),          32'd1);
        check("rst_err",      32'(proto_err),      32'd0);
    endtask

    // Assert reset a little after a rising edge, check immediately, release
    // on a falling edge.
    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        valid_up_in   = 1'b0;
        data_in       = '0;
        ready_down_in = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
    endtask

    initial begin
        logic             pend_v;
        logic [WIDTH-1:0] pend_d;
        int               cyc;
        int               max_count;

        rst           = 1'b1;
        valid_up_in   = 1'b0;
        data_in       = '0;
        ready_down_in = 1'b0;
        accepted      = 0;
        model_reset();
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b0);
        check("ready_after_reset", 32'(ready_up_out), 32'd1);

        // Fill to full with downstream stalled; a fifth word is refused.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA1 + 32'(i), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        cycle(1'b1, 32'hA5, 1'b0);
        cycle(1'b1, 32'hA5, 1'b0);
        check("fill_count", 32'(count), 32'd4);
        check("fill_head",  data_out,    32'hA1);

        // Drain with no push; withdrawing the stalled fifth word is a retraction.
        for (int i = 0; i < 4; i++) begin
            check("drain_order", data_out, 32'hA1 + 32'(i));
            cycle(1'b0, '0, 1'b1);
            if (i == 0) check("ready_after_pop", 32'(ready_up_out), 32'd1);
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("retract_err", 32'(proto_err), 32'd1);

        // Mid-stream reset with three words held.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hB0 + 32'(i), 1'b0);
        check("held_three", 32'(count), 32'd3);
        apply_reset();
        cycle(1'b0, '0, 1'b0);
        check("ready_after_midrst", 32'(ready_up_out), 32'd1);

        // Continuous stream, both sides always ready.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 32'(i), 1'b1);
            check("stream_latency", data_out, 32'(i));
            check("stream_count",   32'(count), 32'd1);
        end
        cycle(1'b0, '0, 1'b1);
        check("stream_drained", 32'(empty), 32'd1);

        // Random traffic obeying the upstream rules.
        accepted  = 0;
        pend_v    = 1'b0;
        pend_d    = '0;
        cyc       = 0;
        max_count = 0;
        while (accepted < 1000 && cyc < 20000) begin
            if (!pend_v) begin
                pend_v = 1'($urandom_range(0, 1));
                pend_d = $urandom;
            end
            cycle(pend_v, pend_d, 1'($urandom_range(0, 1)));
            if (m_up) pend_v = 1'b0;
            if (int'(count) > max_count) max_count = int'(count);
            cyc++;
        end
        check("random_done", 32'(accepted >= 1000), 32'd1);
        check("random_max_count", 32'(max_count <= 4), 32'd1);
        check("random_no_err", 32'(proto_err), 32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        check("random_drained", 32'(empty), 32'd1);

        // Data changed while stalled on full.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h11 + 32'(i), 1'b0);
        cycle(1'b1, 32'h55, 1'b0);
        check("pre_change_err", 32'(proto_err), 32'd0);
        cycle(1'b1, 32'h66, 1'b0);
        check("data_change_err", 32'(proto_err), 32'd1);
        cycle(1'b1, 32'h66, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("contents_intact", data_out, 32'h11 + 32'(i));
            cycle(1'b0, '0, 1'b1);
        end
        check("err_sticky", 32'(proto_err), 32'd1);
        apply_reset();
        cycle(1'b0, '0, 1'b0);
        check("err_cleared", 32'(proto_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/node_fifo_validready.md
# node_fifo_validready

Elastic buffer stage placed directly downstream of a valid/ready node: accepts words from the upstream node's `data_out`/`valid_down_out` and presents them to the next node under the same valid/ready protocol. It absorbs back-pressure bubbles with a DEPTH-entry first-word-fall-through FIFO. It also monitors the upstream side for handshake-rule violations, reported through a sticky error flag.

## Interface
- `WIDTH`, 32: data word width in bits.
- `DEPTH`, 4: number of FIFO entries; must be a power of two, ≥ 2.
- Derived `CW` = $clog2(DEPTH)+1: width of the occupancy count.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `data_in`  in  WIDTH  word from upstream.
- `valid_up_in`  in  1  upstream word is valid.
- `ready_up_out`  out  1  this stage can accept a word.
- `data_out`  out  WIDTH  head-of-FIFO word to downstream.
- `valid_down_out`  out  1  `data_out` is valid.
- `ready_down_in`  in  1  downstream accepts a word.
- `count`  out  CW  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `proto_err`  out  1  sticky upstream protocol-violation flag.

## Operation
- Handshake definitions:
  - `up_fire = valid_up_in & ready_up_out`
  - `down_fire = valid_down_out & ready_down_in`
- Output derivation:
  - `ready_up_out = !full` and `valid_down_out = !empty`.
  - Both are derived only from registered state. There is no combinational path from `ready_down_in` to `ready_up_out`, nor from `valid_up_in` to `valid_down_out`.
- Storage: `mem[DEPTH]`, write pointer `wr_ptr`, read pointer `rd_ptr`, each $clog2(DEPTH) bits.
  - Pointers wrap naturally from DEPTH-1 to 0.
  - `count` is held in its own register.
- On `up_fire`: `mem[wr_ptr] <= data_in`, then `wr_ptr++`.
- On `down_fire`: `rd_ptr++`.
- `data_out = mem[rd_ptr]`, first-word-fall-through.
- Count update:
  - +1 on `up_fire` only.
  - −1 on `down_fire` only.
  - Unchanged when both fire or when neither fires.
- Simultaneous push and pop:
  - Legal at any count 1..DEPTH-1.
  - At count 0, only a push is possible, since `valid_down_out` is 0.
  - At count DEPTH, only a pop is possible, since `ready_up_out` is 0.
  - After a pop from full, `ready_up_out` rises the next cycle. There is no same-cycle pass-through.
- Downstream stability: while `valid_down_out & !ready_down_in`, `data_out` and `valid_down_out` hold unchanged.
- Protocol monitor: sets `proto_err` in the cycle after it sees, in the previous cycle, `valid_up_in & !ready_up_out`, and in the current cycle either of:
  - `valid_up_in == 0` (valid retracted), or
  - `data_in` changed.
- `proto_err` clears only on `rst`. The FIFO never refuses or corrupts data because of it.

## Timing
- Reset values while `rst` is high:
  - `ready_up_out`=0, `valid_down_out`=0, `data_out`=0, `count`=0, `full`=0, `empty`=1, `proto_err`=0.
  - `mem`, pointers and monitor history are all cleared.
- After reset:
  - `ready_up_out`=1 in the first cycle after `rst` falls.
  - Asserting `rst` mid-operation discards all contents immediately and asynchronously.
- Latency: a word accepted on edge N appears on `data_out` with `valid_down_out`=1 after edge N (one cycle, empty FIFO).
- Throughput: one word per cycle sustained when downstream is always ready.
- `full`/`empty`/`count` update on the same edge as the causing fire.

## Structure
- Shared package `node_pkg`:
  - `localparam` default WIDTH.
  - `function automatic clog2_min1` for pointer widths.
  - Typedef `vr_err_t` for future error codes.
- FIFO storage, pointers and count stay in the top module.
- One natural sub-module, `vr_protocol_mon` (params WIDTH; ports `clk`, `rst`, `valid`, `ready`, `data`, `err`). It is reused later on the downstream side of other nodes.

## Test plan
- Reset with `rst`=1 mid-stream, 3 words held → all outputs at reset values in the same cycle; `count`=0; `ready_up_out`=1 one cycle after release.
- Push 0xA1, 0xA2, 0xA3, 0xA4 with `ready_down_in`=0, DEPTH=4 → `full`=1, `ready_up_out`=0, `count`=4; a 5th valid word is not accepted; `data_out`=0xA1 held stable.
- From full, `ready_down_in`=1 for 4 cycles, no push → outputs 0xA1..0xA4 in order; `empty`=1 after the 4th pop; `ready_up_out`=1 one cycle after the first pop.
- Continuous stream 0x00..0x0F, both sides always ready → one word per cycle, one-cycle latency, `count` constant at 1, pointers wrap, order preserved.
- Random `valid_up_in`/`ready_down_in` over 1000 words → scoreboard order exact, `count` never exceeds 4, `proto_err`=0.
- While stalled on full, upstream changes `data_in` from 0x55 to 0x66 with valid held → `proto_err`=1 next cycle and stays 1 until `rst`; stored contents unaffected.
